apb_master: RTL and testbench

Requester-side APB bridge placed directly upstream of the team's APB RAM completer. It accepts one command at a time on a valid/ready command port, runs the APB SETUP/ACCESS protocol on PSEL/PENABLE with PREADY wait-state support, and returns read data plus error status on a valid/ready response port. A watchdog stops the block from hanging on a completer that never asserts PREADY.

---
 rtl/apb_master.sv | 122 ++++++++++++
 tb/tb_apb_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester bridge: one command at a time from a valid/ready command port,
// SETUP/ACCESS sequencing with PREADY wait states, and a response port that
// carries read data and error status. A watchdog bounds the ACCESS phase.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // A zero TIMEOUT still needs a one-bit counter to keep the logic legal.
  localparam int unsigned CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TMO);

  // State register; reset returns to IDLE and drops any in-flight transfer.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and state-decoded handshake / APB control outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = PRESETn;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, ACCESS wait counter and response capture.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
          end
        end
        SETUP: wait_cnt <= CW'(1);
        ACCESS: begin
          // PREADY wins over the watchdog on the same cycle.
          if (PREADY) begin
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
          end else if (timed_out) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: expected responses are queued at command
// issue and checked by a monitor when the response handshake completes.
module tb_apb_master;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t        sb[$];
  int          nchecks = 0;
  int          npass = 0;
  int          prot_err = 0;
  int          wait_n = 0;
  logic        slverr_cfg = 1'b0;
  int          acc = 0;
  int          en_cnt = 0;
  int          setup_cnt = 0;
  logic [31:0] mem [0:255];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Completer model: PREADY rises after wait_n stalled ACCESS cycles.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY  = (acc == wait_n);
      PSLVERR = PREADY && slverr_cfg;
      PRDATA  = mem[PADDR[7:0]];
      if (PREADY && PWRITE) mem[PADDR[7:0]] = PWDATA;
      acc++;
      en_cnt++;
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      acc     = 0;
      if (PSEL) setup_cnt++;
    end
    if ((PENABLE && !PSEL) || (rsp_valid && PSEL)) prot_err++;
  end

  // Response monitor: compare against the oldest queued expectation.
  always @(negedge PCLK) begin : monitor
    exp_t e;
    if (PRESETn && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic expect_rsp, input logic [31:0] er,
                       input logic ee, input logic et);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge PCLK); #1; n++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 64'd0, 64'd1);
    if (expect_rsp) sb.push_back('{rdata: er, err: ee, tmo: et});
    en_cnt    = 0;
    setup_cnt = 0;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge PCLK); #1; lat++;
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (rsp_valid && n < 50) begin
      @(posedge PCLK); #1; n++;
    end
    chk("rsp_drain", rsp_valid, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset held with a command pending: nothing accepted, outputs zero.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h99;
    cmd_write = 1'b1;
    cmd_wdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      chk("reset_ctl", {cmd_ready, PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout, PWRITE}, 64'd0);
      chk("reset_bus", {PADDR, PWDATA}, 64'd0);
      chk("reset_rdata", rsp_rdata, 64'd0);
    end
    cmd_valid = 1'b0;
    PRESETn   = 1'b1;
    #1;
    chk("cmd_ready_after_reset", cmd_ready, 64'd1);
    @(posedge PCLK); #1;

    // Zero-wait write then read.
    wait_n = 0; slverr_cfg = 1'b0;
    issue(32'h5, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_rsp(lat);
    chk("wr_latency", lat, 64'd2);
    chk("wr_setup_cycles", setup_cnt, 64'd1);
    chk("wr_access_cycles", en_cnt, 64'd1);
    drain();
    issue(32'h5, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    wait_rsp(lat);
    chk("rd_latency", lat, 64'd2);
    chk("rd_access_cycles", en_cnt, 64'd1);
    drain();

    // Three wait states, then PSLVERR.
    wait_n = 3; slverr_cfg = 1'b1;
    issue(32'h40, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    wait_rsp(lat);
    chk("err_latency", lat, 64'd5);
    chk("err_access_cycles", en_cnt, 64'd4);
    drain();
    slverr_cfg = 1'b0;

    // Watchdog expiry after four ACCESS cycles.
    wait_n = 1000;
    issue(32'h5, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_rsp(lat);
    chk("tmo_latency", lat, 64'd5);
    chk("tmo_access_cycles", en_cnt, 64'd4);
    chk("tmo_psel", {PSEL, PENABLE}, 64'd0);
    drain();

    // PREADY on the fourth ACCESS cycle completes normally.
    wait_n = 3;
    issue(32'h5, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    wait_rsp(lat);
    chk("edge_latency", lat, 64'd5);
    drain();

    // Response backpressure for five cycles.
    wait_n = 0;
    rsp_ready = 1'b0;
    issue(32'h5, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    wait_rsp(lat);
    chk("bp_latency", lat, 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      chk("bp_hold_ctl", {rsp_valid, cmd_ready, PSEL, PENABLE, rsp_err, rsp_timeout}, 64'b100000);
      chk("bp_hold_rdata", rsp_rdata, 64'hDEADBEEF);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    chk("bp_release", {rsp_valid, cmd_ready}, 64'b01);

    // Reset during a wait state drops the transfer silently.
    wait_n = 1000;
    issue(32'h20, 1'b1, 32'hAAAA5555, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("mid_in_access", {PSEL, PENABLE}, 64'b11);
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    chk("mid_reset_ctl", {PSEL, PENABLE, rsp_valid}, 64'd0);
    chk("mid_reset_addr", PADDR, 64'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("mid_after_release", {rsp_valid, cmd_ready}, 64'b01);
    wait_n = 0;
    issue(32'h20, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_rsp(lat);
    chk("post_reset_latency", lat, 64'd2);
    drain();
    issue(32'h5, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    wait_rsp(lat);
    drain();

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge PCLK);
    chk("scoreboard_empty", sb.size(), 64'd0);
    chk("protocol_violations", prot_err, 64'd0);
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end
endmodule
